// File: rtl/alu_issue_queue.sv
// Command FIFO and issue sequencer for the 16-bit registered ALU stage.
// Issues one command at a time, captures the result and returns it with its tag on a valid/ready port.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  input  logic [4:0]       cmd_sel,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_packed_in,
  output logic [4:0]       alu_sel,
  input  logic [31:0]      alu_packed_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             err_illegal,
  output logic [AW:0]      level,
  output logic [1:0]       dbg_state
);

  // Both ports are valid/ready: a transfer happens on a rising edge where valid && ready are high.
  // Producers hold payload stable while valid is high and ready is low.

  localparam int EW = TAG_W + 37;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [1:0]       r_state;
  logic [31:0]      r_alu_in;
  logic [4:0]       r_alu_sel;
  logic [TAG_W-1:0] r_tag;
  logic             r_res_valid;
  logic [31:0]      r_res_data;
  logic [TAG_W-1:0] r_res_tag;
  logic             r_err;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [EW-1:0]    w_head;
  logic [15:0]      w_head_a;
  logic [15:0]      w_head_b;
  logic [4:0]       w_head_sel;
  logic [TAG_W-1:0] w_head_tag;
  logic             w_head_illegal;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == (AW+1)'(DEPTH));
  assign w_push  = cmd_valid && !w_full;
  // Pops only from registered occupancy, so a command written this cycle is never popped this cycle.
  assign w_pop   = !w_empty && ((r_state == S_IDLE) || ((r_state == S_HOLD) && res_ready));

  assign w_head         = r_mem[r_rd_ptr];
  assign w_head_a       = w_head[15:0];
  assign w_head_b       = w_head[31:16];
  assign w_head_sel     = w_head[36:32];
  assign w_head_tag     = w_head[EW-1:37];
  assign w_head_illegal = (w_head_sel[4:3] == 2'b11);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_tag, cmd_sel, cmd_b, cmd_a};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + (AW+1)'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_alu_in    <= '0;
      r_alu_sel   <= '0;
      r_tag       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_tag   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE, S_HOLD: begin
          if ((r_state == S_HOLD) && res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
          // HOLD with an accepted result dispatches the next head exactly as IDLE does.
          if (w_pop) begin
            if (w_head_illegal) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_alu_in  <= {w_head_b, w_head_a};
              r_alu_sel <= w_head_sel;
              r_tag     <= w_head_tag;
              r_state   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_res_data  <= alu_packed_out;
          r_res_tag   <= r_tag;
          r_res_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = !w_full;
  assign alu_packed_in = r_alu_in;
  assign alu_sel       = r_alu_sel;
  assign res_valid     = r_res_valid;
  assign res_data      = r_res_data;
  assign res_tag       = r_res_tag;
  assign err_illegal   = r_err;
  assign level         = r_level;
  assign dbg_state     = r_state;

endmodule
